// File: rtl/led_strip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_strip_sequencer
// Brief    : Steps a WIDTH-LED run / bounce / bar pattern once per ok toggle.
//            Optional PWM dimming of the LED drive via macro LED_PWM_DIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_strip_sequencer #(
    parameter int WIDTH = 16,
    parameter int DUTY  = 8
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [1:0]       MOD,
    input  logic             ok,
    output logic [WIDTH-1:0] LEDs_strip,
    output logic             wrap
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FW = $clog2(WIDTH + 1);

    localparam logic [PW-1:0]    c_pos_max   = PW'(WIDTH - 1);
    localparam logic [FW-1:0]    c_fill_max  = FW'(WIDTH);
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
    localparam logic [1:0]       c_mode_run  = 2'd1;
    localparam logic [1:0]       c_mode_bnc  = 2'd2;
    localparam logic [1:0]       c_mode_bar  = 2'd3;

    if (WIDTH < 2 || DUTY < 0 || DUTY > 16) begin : g_param_check
        $error("led_strip_sequencer: WIDTH must be >= 2 and DUTY in 0..16");
    end

    logic             r_s1, r_s2, r_s3;
    logic [1:0]       r_mod_q;
    logic [PW-1:0]    r_pos;
    logic             r_dir_down;
    logic [FW-1:0]    r_fill;
    logic [WIDTH-1:0] r_pattern;
    logic             r_wrap;

    logic             w_step;
    logic [PW-1:0]    w_pos_inc, w_pos_dec, w_pos_run;
    logic             w_pos_at_max;
    logic [FW-1:0]    w_fill_inc;
    logic             w_fill_at_max;
    logic [WIDTH-1:0] w_bar;

    logic [PW-1:0]    w_pos_nxt;
    logic             w_dir_nxt;
    logic [FW-1:0]    w_fill_nxt;
    logic [WIDTH-1:0] w_pat_nxt;
    logic             w_wrap_nxt;

    // A step is the single-cycle difference between the synchronized level and its delayed copy.
    assign w_step        = r_s2 ^ r_s3;
    assign w_pos_inc     = r_pos + 1'b1;
    assign w_pos_dec     = r_pos - 1'b1;
    assign w_pos_at_max  = (r_pos == c_pos_max);
    assign w_pos_run     = w_pos_at_max ? '0 : w_pos_inc;
    assign w_fill_at_max = (r_fill == c_fill_max);
    assign w_fill_inc    = w_fill_at_max ? '0 : r_fill + 1'b1;
    // Shifting all-ones by fill (fill == WIDTH shifts everything out) yields the bar mask.
    assign w_bar         = ~({WIDTH{1'b1}} << w_fill_inc);

    always_comb begin
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir_down;
        w_fill_nxt = r_fill;
        w_pat_nxt  = r_pattern;
        w_wrap_nxt = 1'b0;
        if (MOD != r_mod_q) begin
            w_pos_nxt  = '0;
            w_dir_nxt  = 1'b0;
            w_fill_nxt = '0;
            w_pat_nxt  = (MOD == c_mode_run || MOD == c_mode_bnc) ? c_one : '0;
        end else if (w_step) begin
            case (r_mod_q)
                c_mode_run: begin
                    w_pos_nxt  = w_pos_run;
                    w_pat_nxt  = c_one << w_pos_run;
                    w_wrap_nxt = w_pos_at_max;
                end
                c_mode_bnc: begin
                    if (!r_dir_down) begin
                        w_pos_nxt = w_pos_inc;
                        w_dir_nxt = (w_pos_inc == c_pos_max);
                    end else begin
                        w_pos_nxt  = w_pos_dec;
                        w_dir_nxt  = (w_pos_dec != '0);
                        w_wrap_nxt = (w_pos_dec == '0);
                    end
                    w_pat_nxt = c_one << w_pos_nxt;
                end
                c_mode_bar: begin
                    w_fill_nxt = w_fill_inc;
                    w_pat_nxt  = w_bar;
                    w_wrap_nxt = w_fill_at_max;
                end
                default: begin
                    w_pat_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_mod_q    <= 2'd0;
            r_pos      <= '0;
            r_dir_down <= 1'b0;
            r_fill     <= '0;
            r_pattern  <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_s1       <= ok;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_mod_q    <= MOD;
            r_pos      <= w_pos_nxt;
            r_dir_down <= w_dir_nxt;
            r_fill     <= w_fill_nxt;
            r_pattern  <= w_pat_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign wrap = r_wrap;

`ifdef LED_PWM_DIM_EN
    logic [3:0] r_pwm_cnt;
    logic       w_pwm_on;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_pwm_on   = ({1'b0, r_pwm_cnt} < 5'(DUTY));
    assign LEDs_strip = r_pattern & {WIDTH{w_pwm_on}};
`else
    assign LEDs_strip = r_pattern;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_strip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_strip_sequencer
// Brief    : Vector table, directed corner sequences and random ok/MOD traffic
//            compared against a step-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_strip_sequencer;

    localparam int W    = 16;
    localparam int DUTY = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mod;
    logic         ok;
    logic [W-1:0] leds;
    logic         wrap;

    always #5 clk = ~clk;

    led_strip_sequencer #(.WIDTH(W), .DUTY(DUTY)) u_dut (
        .CLOCK      (clk),
        .RESET_N    (rst_n),
        .MOD        (mod),
        .ok         (ok),
        .LEDs_strip (leds),
        .wrap       (wrap)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a mode, a step count since the mode was loaded, and a
    // three-edge delay line from an ok toggle to its pattern update.
    int         m_mode, m_k, m_pwm;
    logic       m_wrap;
    logic [2:0] m_pend;
    int         wrap_seen;

    function automatic int period(input int md);
        case (md)
            1:       return W;
            2:       return 2 * (W - 1);
            3:       return W + 1;
            default: return 1;
        endcase
    endfunction

    function automatic logic [W-1:0] pattern(input int md, input int k);
        logic [W-1:0] p;
        int j;
        p = '0;
        case (md)
            1: begin p[0] = 1'b1; p = p << k; end
            2: begin
                j = (k < W) ? k : 2 * (W - 1) - k;
                p[0] = 1'b1;
                p = p << j;
            end
            3: for (int i = 0; i < k; i++) p[i] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [W-1:0] gmask();
`ifdef LED_PWM_DIM_EN
        return (m_pwm < DUTY) ? {W{1'b1}} : {W{1'b0}};
`else
        return {W{1'b1}};
`endif
    endfunction

    function automatic logic [W-1:0] exp_leds();
        return pattern(m_mode, m_k) & gmask();
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_pwm = 0; m_wrap = 1'b0; m_pend = '0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic cycle();
        logic step_now;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_pwm    = (m_pwm + 1) % 16;
            step_now = m_pend[2];
            m_pend   = {m_pend[1:0], 1'b0};
            if (int'(mod) != m_mode) begin
                m_mode = int'(mod); m_k = 0; m_wrap = 1'b0;
            end else if (step_now && m_mode != 0) begin
                m_k    = m_k + 1;
                m_wrap = (m_k == period(m_mode));
                if (m_wrap) m_k = 0;
            end else begin
                m_wrap = 1'b0;
            end
        end
        #1;
        if (wrap === 1'b1) wrap_seen++;
        chk("model_leds", leds, exp_leds());
        chk("model_wrap", {{(W-1){1'b0}}, wrap}, {{(W-1){1'b0}}, m_wrap});
    endtask

    task automatic toggle();
        ok = ~ok;
        if (rst_n) m_pend[0] = 1'b1;
    endtask

    task automatic load_mode(input logic [1:0] md);
        mod = 2'd0; repeat (3) cycle();
        mod = md;   repeat (3) cycle();
    endtask

    typedef struct {
        logic [1:0]   md;
        int           n;
        logic [W-1:0] leds;
        int           wraps;
    } vec_t;

    vec_t vecs[13];
    int   since;
    int   on_cnt;

    initial begin
        vecs[0]  = '{2'd1, 0,  16'h0001, 0};
        vecs[1]  = '{2'd1, 5,  16'h0020, 0};
        vecs[2]  = '{2'd1, 15, 16'h8000, 0};
        vecs[3]  = '{2'd1, 16, 16'h0001, 1};
        vecs[4]  = '{2'd2, 15, 16'h8000, 0};
        vecs[5]  = '{2'd2, 16, 16'h4000, 0};
        vecs[6]  = '{2'd2, 30, 16'h0001, 1};
        vecs[7]  = '{2'd2, 32, 16'h0004, 1};
        vecs[8]  = '{2'd3, 0,  16'h0000, 0};
        vecs[9]  = '{2'd3, 4,  16'h000F, 0};
        vecs[10] = '{2'd3, 16, 16'hFFFF, 0};
        vecs[11] = '{2'd3, 17, 16'h0000, 1};
        vecs[12] = '{2'd0, 5,  16'h0000, 0};

        rst_n = 1'b0; mod = 2'd1; ok = 1'b0;
        model_reset();

        // Reset held with activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            ok = ~ok;
            cycle();
        end
        chk("reset_leds", leds, 16'h0000);
        chk("reset_wrap", {{(W-1){1'b0}}, wrap}, 16'h0000);
        ok = 1'b0; rst_n = 1'b1;
        repeat (3) cycle();
        for (int i = 0; i < 3; i++) begin
            toggle(); repeat (5) cycle();
        end
        // Asynchronous assertion mid-cycle clears the drive before any edge.
        #2 rst_n = 1'b0;
        #1 chk("async_reset_leds", leds, 16'h0000);
        model_reset();
        cycle();
        ok = 1'b0; rst_n = 1'b1;
        repeat (2) cycle();

        // Update lands on the third edge after the toggle.
        load_mode(2'd1);
        chk("lat_start", leds, 16'h0001 & gmask());
        toggle();
        cycle(); chk("lat_edge1", leds, 16'h0001 & gmask());
        cycle(); chk("lat_edge2", leds, 16'h0001 & gmask());
        cycle(); chk("lat_edge3", leds, 16'h0002 & gmask());
        repeat (3) cycle();

        // Mode change coincident with a step: step dropped, new mode starts clean.
        toggle();
        cycle(); cycle();
        mod = 2'd3;
        cycle();
        chk("modchg_leds", leds, 16'h0000);
        chk("modchg_wrap", {{(W-1){1'b0}}, wrap}, 16'h0000);
        repeat (5) cycle();
        toggle(); repeat (6) cycle();
        chk("modchg_next", leds, 16'h0001 & gmask());

        // Table of step counts per mode.
        for (int v = 0; v < 13; v++) begin
            load_mode(vecs[v].md);
            wrap_seen = 0;
            for (int t = 0; t < vecs[v].n; t++) begin
                toggle(); repeat (6) cycle();
            end
            repeat (6) cycle();
            chk($sformatf("vec%0d_leds", v), leds, vecs[v].leds & gmask());
            chk_int($sformatf("vec%0d_wraps", v), wrap_seen, vecs[v].wraps);
        end

`ifdef LED_PWM_DIM_EN
        load_mode(2'd1);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (leds[0] === 1'b1) on_cnt++;
        end
        chk_int("pwm_on_slots", on_cnt, DUTY);
`endif

        // Random ok/MOD traffic against the model.
        since = 10;
        for (int c = 0; c < 3000; c++) begin
            if (since >= 4 && $urandom_range(0, 3) == 0) begin
                toggle(); since = 0;
            end else begin
                since++;
            end
            if ($urandom_range(0, 59) == 0) mod = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
